uart_rx_cfg: RTL

Parametrised UART receiver for the colour-sensor link, sitting between the serial pin and the message-decode logic on the 3.125 MHz domain. It generalises the fixed 8-bit/14-cycle receiver with configurable bit period, data width and stop bits, and adds mid-bit sampling with false-start rejection. It also adds per-frame parity and framing error flags, overrun detection, and a small first-word-fall-through receive FIFO with a valid/ready handshake.

---
 rtl/uart_rx_cfg.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_cfg.sv
// UART receiver with mid-bit sampling, false-start rejection, error flags and a FWFT receive FIFO.
// Parity checking is compiled in only when UART_RX_PARITY_EN is defined.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 14,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk_3125,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int IW  = $clog2(DATA_BITS);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int MID = CLKS_PER_BIT / 2;
`ifdef UART_RX_PARITY_EN
  localparam int   EW  = DATA_BITS + 2;
  localparam logic ODD = (PARITY_ODD != 0);
`else
  localparam int EW = DATA_BITS + 1;
`endif
  localparam logic [CW-1:0] CNT_MID   = CW'(MID - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);

  if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || (PARITY_ODD != 0 && PARITY_ODD != 1) ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("uart_rx_cfg: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [1:0] sync_q;
  logic       rs;

  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx};
  end
  assign rs = sync_q[1];

  state_t               state_q;
  logic                 armed_q;
  logic                 busy_q;
  logic [CW-1:0]        cnt_q;
  logic [IW-1:0]        bit_q;
  logic                 stop_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 ferr_q;
`ifdef UART_RX_PARITY_EN
  logic                 par_acc_q;
  logic                 perr_q;
`endif

  logic          tick;
  logic          push;
  logic [EW-1:0] push_entry;

  assign tick = (cnt_q == CNT_LAST);
  assign push = (state_q == S_STOP) && tick && (stop_q == STOP_LAST);
  // The last stop sample is folded in directly so the push lands on the sampling edge.
`ifdef UART_RX_PARITY_EN
  assign push_entry = {shift_q, perr_q, ferr_q | ~rs};
`else
  assign push_entry = {shift_q, ferr_q | ~rs};
`endif

  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      armed_q   <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      bit_q     <= '0;
      stop_q    <= 1'b0;
      shift_q   <= '0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_acc_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          if (!armed_q) begin
            armed_q <= rs;
          end else if (!rs) begin
            state_q   <= S_START;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            bit_q     <= '0;
            stop_q    <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_acc_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
          end
        end
        S_START: begin
          if (cnt_q == CNT_MID) begin
            cnt_q <= '0;
            if (rs) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            cnt_q   <= '0;
            shift_q <= {rs, shift_q[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
            par_acc_q <= par_acc_q ^ rs;
`endif
            if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            cnt_q   <= '0;
            perr_q  <= rs ^ par_acc_q ^ ODD;
            state_q <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (tick) begin
            cnt_q <= '0;
            if (!rs) ferr_q <= 1'b1;
            if (stop_q == STOP_LAST) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              armed_q <= rs;
            end else begin
              stop_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   count_q, count_d;
  logic          overrun_q;
  logic          pop, full, do_push;
  logic [EW-1:0] head;

  assign pop     = rx_valid && rx_ready;
  assign full    = (count_q == CNT_FULL);
  assign do_push = push && (!full || pop);
  assign count_d = count_q + (AW + 1)'(do_push) - (AW + 1)'(pop);

  always_ff @(posedge clk_3125) begin
    if (do_push) mem_q[wr_q] <= push_entry;
  end

  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= push && full && !pop;
      if (do_push) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign head         = mem_q[rd_q];
  assign rx_valid     = (count_q != '0);
  assign rx_data      = rx_valid ? head[EW-1 -: DATA_BITS] : '0;
  assign rx_frame_err = rx_valid & head[0];
`ifdef UART_RX_PARITY_EN
  assign rx_parity_err = rx_valid & head[1];
`else
  assign rx_parity_err = 1'b0;
`endif
  assign rx_overrun = overrun_q;
  assign rx_busy    = busy_q;

endmodule
